// File: rtl/sr_latch_pkg.sv
// Shared types for the SR latch controller: FSM states, command opcodes, counter width.
package sr_latch_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } stateT;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_SET   = 2'b01,
    OP_RESET = 2'b10,
    OP_RSVD  = 2'b11
  } opT;

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// Command/status handshake of the SR latch controller; master issues commands, slave executes.
interface sr_latch_ctrl_if;

  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;
  logic       done;
  logic       result_q;
  logic       err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op,
    input  cmd_ready, done, result_q, err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op,
    output cmd_ready, done, result_q, err, busy
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit; two cycles of latency, resets to 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// Drives an external NAND SR latch with timed active-low pulses and verifies the result.
// Latency accept->done: PULSE_CYC+SETTLE_CYC+1 (SET/RESET), SETTLE_CYC+1 (NOP), 2 (reserved); one command at a time.
module sr_latch_ctrl
  import sr_latch_pkg::*;
#(
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 3
) (
  input  logic            clk,
  input  logic            rst,
  sr_latch_ctrl_if.slave  cmd,
  output logic            S_n,
  output logic            R_n,
  input  logic            q_in,
  input  logic            qc_in
);

  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  stateT            state;
  logic [CNT_W-1:0] cnt;
  opT               opReg;
  logic             expQ;
  logic             qSync;
  logic             qcSync;

  sync2 uSyncQ  (.clk(clk), .rst(rst), .d(q_in),  .q(qSync));
  sync2 uSyncQc (.clk(clk), .rst(rst), .d(qc_in), .q(qcSync));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      opReg        <= OP_NOP;
      expQ         <= 1'b0;
      S_n          <= 1'b1;
      R_n          <= 1'b1;
      cmd.cmd_ready <= 1'b0;
      cmd.busy     <= 1'b0;
      cmd.done     <= 1'b0;
      cmd.result_q <= 1'b0;
      cmd.err      <= 1'b0;
    end else begin
      cmd.done <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd.cmd_ready <= 1'b1;
          if (cmd.cmd_valid && cmd.cmd_ready) begin
            opReg         <= opT'(cmd.cmd_op);
            cmd.cmd_ready <= 1'b0;
            cmd.busy      <= 1'b1;
            unique case (opT'(cmd.cmd_op))
              OP_SET: begin
                expQ  <= 1'b1;
                S_n   <= 1'b0;
                cnt   <= PULSE_LOAD;
                state <= PULSE;
              end
              OP_RESET: begin
                expQ  <= 1'b0;
                R_n   <= 1'b0;
                cnt   <= PULSE_LOAD;
                state <= PULSE;
              end
              OP_NOP: begin
                expQ  <= cmd.result_q;
                cnt   <= SETTLE_LOAD;
                state <= SETTLE;
              end
              OP_RSVD: begin
                // one settle cycle so done lands two cycles after accept
                expQ  <= cmd.result_q;
                cnt   <= '0;
                state <= SETTLE;
              end
            endcase
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            S_n   <= 1'b1;
            R_n   <= 1'b1;
            cnt   <= SETTLE_LOAD;
            state <= SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            cmd.done <= 1'b1;
            state    <= CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          cnt           <= '0;
          cmd.busy      <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= IDLE;
          if (opReg == OP_RSVD) begin
            cmd.err <= 1'b1;
          end else begin
            cmd.result_q <= qSync;
            // Q==Qc means the latch never resolved (or was driven into the forbidden state)
            if ((qSync != expQ) || (qSync == qcSync)) cmd.err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_ctrl.sv
// Directed + random bench for sr_latch_ctrl driving a behavioural NAND SR latch.
module tb_sr_latch_ctrl;

  localparam int P = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst;
  logic sN, rN;
  logic qIn, qcIn;

  sr_latch_ctrl_if bus ();

  sr_latch_ctrl #(.PULSE_CYC(P), .SETTLE_CYC(S)) dut (
    .clk   (clk),
    .rst   (rst),
    .cmd   (bus),
    .S_n   (sN),
    .R_n   (rN),
    .q_in  (qIn),
    .qc_in (qcIn)
  );

  always #5 clk = ~clk;

  // Behavioural NAND SR latch; forceBoth overrides both outputs to 1.
  logic latQ  = 1'b0;
  logic latQc = 1'b1;
  logic forceBoth = 1'b0;

  always @(sN or rN) begin
    if (sN === 1'b0 && rN === 1'b1) begin
      latQ = 1'b1; latQc = 1'b0;
    end else if (sN === 1'b1 && rN === 1'b0) begin
      latQ = 1'b0; latQc = 1'b1;
    end else if (sN === 1'b0 && rN === 1'b0) begin
      latQ = 1'b1; latQc = 1'b1;
    end
  end

  assign qIn  = forceBoth ? 1'b1 : latQ;
  assign qcIn = forceBoth ? 1'b1 : latQc;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the latch holds, what result_q/err should read.
  logic mLatch  = 1'b0;
  logic mResult = 1'b0;
  logic mErr    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) check("sr_never_both_low", {31'b0, (sN | rN)}, 32'd1);
  end

  task automatic doCmd(input logic [1:0] op, input bit forceMid);
    int   lat, sLow, rLow, sFirst, sLast, rFirst, rLast, expLat, expS, expR;
    logic want, smpQ, smpQc;
    expLat = (op == 2'b11) ? 2 : (op == 2'b00) ? S + 1 : P + S + 1;
    expS   = (op == 2'b01) ? P : 0;
    expR   = (op == 2'b10) ? P : 0;
    if (op == 2'b01) mLatch = 1'b1;
    if (op == 2'b10) mLatch = 1'b0;
    if (op == 2'b11) begin
      mErr = 1'b1;
    end else begin
      want  = (op == 2'b01) ? 1'b1 : (op == 2'b10) ? 1'b0 : mResult;
      smpQ  = forceMid ? 1'b1 : mLatch;
      smpQc = forceMid ? 1'b1 : ~mLatch;
      if (smpQ != want || smpQ == smpQc) mErr = 1'b1;
      mResult = smpQ;
    end

    check("ready_before_cmd", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    lat = 0; sLow = 0; rLow = 0; sFirst = 0; sLast = 0; rFirst = 0; rLast = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(negedge clk);
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 2'($urandom);
      if (forceMid && c == expS + expR + 1) forceBoth = 1'b1;
      if (c == 1) begin
        check("busy_in_flight", bus.busy, 1);
        check("ready_in_flight", bus.cmd_ready, 0);
      end
      if (sN === 1'b0) begin sLow++; if (sFirst == 0) sFirst = c; sLast = c; end
      if (rN === 1'b0) begin rLow++; if (rFirst == 0) rFirst = c; rLast = c; end
      if (bus.done === 1'b1) lat = c;
    end
    bus.cmd_valid = 1'b0;
    forceBoth     = 1'b0;
    check("done_latency", lat, expLat);
    check("s_low_cycles", sLow, expS);
    check("r_low_cycles", rLow, expR);
    if (expS > 0) begin
      check("s_first_cycle", sFirst, 1);
      check("s_last_cycle", sLast, P);
    end
    if (expR > 0) begin
      check("r_first_cycle", rFirst, 1);
      check("r_last_cycle", rLast, P);
    end
    @(negedge clk);
    check("done_single_cycle", bus.done, 0);
    check("result_q", bus.result_q, mResult);
    check("err", bus.err, mErr);
    check("ready_after_done", bus.cmd_ready, 1);
    check("busy_after_done", bus.busy, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    mResult = 1'b0;
    mErr    = 1'b0;
    check("reset_err", bus.err, 0);
    check("reset_result_q", bus.result_q, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.cmd_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int doneSeen;
    logic [1:0] op;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_S_n", sN, 1);
    check("reset_R_n", rN, 1);
    check("reset_done", bus.done, 0);
    check("reset_result_q", bus.result_q, 0);
    check("reset_err", bus.err, 0);
    check("reset_busy", bus.busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.cmd_ready, 1);

    doCmd(2'b01, 1'b0);   // SET
    doCmd(2'b10, 1'b0);   // RESET back-to-back
    doCmd(2'b01, 1'b0);   // SET
    doCmd(2'b00, 1'b0);   // NOP readback after SET

    repeat (40) begin
      op = 2'($urandom_range(0, 2));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      doCmd(op, 1'b0);
    end

    // Reset in the second pulse cycle of a SET.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("mid_pulse_S_n_low", sN, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_pulse_rst_S_n", sN, 1);
    check("mid_pulse_rst_R_n", rN, 1);
    check("mid_pulse_rst_busy", bus.busy, 0);
    check("mid_pulse_rst_done", bus.done, 0);
    mLatch  = 1'b1;
    mResult = 1'b0;
    mErr    = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_first_edge_after_rst", bus.cmd_ready, 1);
    doneSeen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1) doneSeen++;
    end
    check("no_done_after_drop", doneSeen, 0);

    doCmd(2'b11, 1'b0);   // reserved: err, result_q unchanged
    doCmd(2'b01, 1'b0);   // err stays sticky
    doReset();

    doCmd(2'b01, 1'b1);   // Q=Qc forced during settle
    doCmd(2'b00, 1'b0);   // err held
    doReset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sr_latch_ctrl.md
SR_LATCH_CTRL -- requirements
Module: sr_latch_ctrl

Interface
REQ-001 Parameter PULSE_CYC, default 4, cycles S_n/R_n held low per command (legal 1..255).
REQ-002 Parameter SETTLE_CYC, default 3, cycles after pulse release before latch outputs are checked (legal 3..255).
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_op  in  2  00 NOP/readback, 01 SET, 10 RESET, 11 reserved.
REQ-007 cmd_ready  out  1  high only in IDLE.
REQ-008 S_n  out  1  active-low set to external NAND SR latch.
REQ-009 R_n  out  1  active-low reset to external NAND SR latch.
REQ-010 q_in  in  1  latch Q, asynchronous to clk.
REQ-011 qc_in  in  1  latch Qc, asynchronous to clk.
REQ-012 done  out  1  one-cycle pulse, command complete.
REQ-013 result_q  out  1  synchronized Q sampled at completion.
REQ-014 err  out  1  sticky error flag.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 FSM states IDLE, PULSE, SETTLE, CHECK; the FSM SHALL hold in IDLE while cmd_valid is low.
REQ-017 Accept on the edge where cmd_valid & cmd_ready are both high; op and the expected Q value (SET=1, RESET=0, NOP=current result_q) are latched on that edge.
REQ-018 SET/RESET: IDLE->PULSE; S_n (SET) or R_n (RESET) low for exactly PULSE_CYC cycles starting the cycle after accept.
REQ-019 NOP: IDLE->SETTLE directly; S_n and R_n stay high throughout.
REQ-020 PULSE->SETTLE after PULSE_CYC cycles; S_n=R_n=1 for SETTLE_CYC cycles; SETTLE->CHECK; CHECK->IDLE after one cycle.
REQ-021 Latency accept->done: PULSE_CYC+SETTLE_CYC+1 cycles for SET/RESET, SETTLE_CYC+1 for NOP; done high only during CHECK.
REQ-022 S_n and R_n SHALL never be low in the same cycle (invariant; state 0/0 is forbidden because a subsequent 1/1 races).
REQ-023 S_n and R_n SHALL be driven from flops; no glitches.
REQ-024 q_in and qc_in pass through a 2-flop synchronizer before any use.
REQ-025 In CHECK: result_q <= synced Q; err set if synced Q != expected or synced Q == synced Qc.
REQ-026 Reserved op 11: accepted, no pulse, FSM goes to CHECK the next cycle, err set, result_q unchanged, done pulses.
REQ-027 err clears only on rst.
REQ-028 cmd_op/cmd_valid changes while busy are ignored; no queuing.
REQ-029 A new command may be accepted on the cycle after done (back-to-back, one IDLE cycle minimum).
REQ-030 Counter width 8 bits; counts wrap is not permitted (terminal count reloads on state exit).

Reset
REQ-031 On rst high, asynchronously: state=IDLE, S_n=1, R_n=1, done=0, result_q=0, err=0, busy=0, counter=0, synchronizer flops=0.
REQ-032 rst asserted mid-PULSE SHALL release S_n/R_n to 1 immediately; the command is dropped with no done.
REQ-033 cmd_ready SHALL go high the first clk edge after rst deasserts.

Structure
REQ-034 Package sr_latch_pkg holds the state enum, op encodings (OP_NOP, OP_SET, OP_RESET, OP_RSVD) and counter width constant.
REQ-035 Sub-module sync2 (2-flop synchronizer, async active-high reset to 0) instantiated twice for q_in and qc_in.
REQ-036 Bench connects S_n/R_n to a behavioral NAND SR latch model driving q_in/qc_in.

Verification
REQ-037 Reset then SET (P=4,S=3): S_n low cycles 1-4 after accept, done at cycle 8, result_q=1, err=0.
REQ-038 SET then RESET back-to-back: R_n low 4 cycles, done, result_q=0, err=0; S_n and R_n never both 0 (assert every cycle).
REQ-039 NOP after SET: no pulse, done 4 cycles after accept, result_q=1, err=0.
REQ-040 Latch model forced Q=Qc=1 during SETTLE: done with err=1, err held until rst.
REQ-041 op=11: done two cycles after accept, err=1, S_n=R_n=1 throughout.
REQ-042 rst asserted in PULSE cycle 2: S_n=1 same time step, no done, cmd_ready=1 first edge after release.
